// File: rtl/ma_threshold_detector.sv
// Hysteresis threshold detector for the moving-average filter output.
// Registered level flag, rise/fall pulses, saturating rise counter and a
// post-transition hold-off that suppresses chatter.
module ma_threshold_detector #(
  parameter logic signed [7:0] TH_HI   = 8'sd20,
  parameter logic signed [7:0] TH_LO   = 8'sd10,
  parameter int                HOLDOFF = 4,
  parameter int                CNT_W   = 16
) (
  input  logic             system1000,
  input  logic             system1000_rstn,
  input  logic [7:0]       avg_i,
  input  logic             sample_en_i,
  input  logic             clear_i,
  output logic             above_o,
  output logic             rise_o,
  output logic             fall_o,
  output logic [CNT_W-1:0] event_cnt_o,
  output logic [1:0]       dbg_state
);

  localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

  typedef enum logic [1:0] {
    ST_LOW       = 2'd0,
    ST_RISE_HOLD = 2'd1,
    ST_HIGH      = 2'd2,
    ST_FALL_HOLD = 2'd3
  } state_t;

  state_t          state;
  logic [HW-1:0]   hold;
  logic signed [7:0] avg_s;
  logic            rise_cond;
  logic            fall_cond;

  // There is no handshake here: sample_en_i is a pure qualifier. When it is 0
  // the sample is ignored, the FSM and hold counter freeze, and pulses drop.
  assign avg_s     = avg_i;
  assign rise_cond = (avg_s >= TH_HI);
  assign fall_cond = (avg_s <= TH_LO);
  assign dbg_state = state;

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      state       <= ST_LOW;
      hold        <= '0;
      above_o     <= 1'b0;
      rise_o      <= 1'b0;
      fall_o      <= 1'b0;
      event_cnt_o <= '0;
    end else if (clear_i) begin
      state       <= ST_LOW;
      hold        <= '0;
      above_o     <= 1'b0;
      rise_o      <= 1'b0;
      fall_o      <= 1'b0;
      event_cnt_o <= '0;
    end else begin
      rise_o <= 1'b0;
      fall_o <= 1'b0;
      if (sample_en_i) begin
        case (state)
          ST_LOW: begin
            if (rise_cond) begin
              rise_o  <= 1'b1;
              above_o <= 1'b1;
              hold    <= '0;
              state   <= (HOLDOFF == 0) ? ST_HIGH : ST_RISE_HOLD;
              if (event_cnt_o != {CNT_W{1'b1}}) begin
                event_cnt_o <= event_cnt_o + CNT_W'(1);
              end
            end
          end
          ST_RISE_HOLD: begin
            // The sample value is irrelevant here; only enabled samples count.
            if (hold == HOLD_LAST) begin
              hold  <= '0;
              state <= ST_HIGH;
            end else begin
              hold <= hold + HW'(1);
            end
          end
          ST_HIGH: begin
            if (fall_cond) begin
              fall_o  <= 1'b1;
              above_o <= 1'b0;
              hold    <= '0;
              state   <= (HOLDOFF == 0) ? ST_LOW : ST_FALL_HOLD;
            end
          end
          ST_FALL_HOLD: begin
            if (hold == HOLD_LAST) begin
              hold  <= '0;
              state <= ST_LOW;
            end else begin
              hold <= hold + HW'(1);
            end
          end
          default: begin
            state <= ST_LOW;
          end
        endcase
      end
    end
  end

endmodule
